// File: rtl/rect_pos_ctl.sv
// Sprite position control: follows the mouse, falls under gravity on left-click, optional floor bounce (RECT_CTL_BOUNCE_EN).
// Updates land on the pclk edge that sees the vsync rising edge; no backpressure, outputs are held between ticks.
module rect_pos_ctl #(
    parameter int WIDTH      = 48,
    parameter int HEIGHT     = 64,
    parameter int H_MAX      = 800,
    parameter int FLOOR      = 600,
    parameter int GRAVITY    = 4,
    parameter int VMAX       = 512,
    parameter int MIN_BOUNCE = 16
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [11:0] xpos_out,
    output logic [11:0] ypos_out,
    output logic        left_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        ST_FOLLOW = 2'b00,
        ST_FALL   = 2'b01,
        ST_RISE   = 2'b10,
        ST_STOP   = 2'b11
    } state_t;

`ifdef RECT_CTL_BOUNCE_EN
    localparam bit BOUNCE_EN = 1'b1;
`else
    localparam bit BOUNCE_EN = 1'b0;
`endif

    localparam logic [11:0] X_MAX   = 12'(H_MAX - WIDTH);
    localparam logic [11:0] Y_MAX   = 12'(FLOOR - HEIGHT);
    localparam logic [15:0] Y_FLOOR = 16'((FLOOR - HEIGHT) * 16);
    localparam logic [11:0] GRAV    = 12'(GRAVITY);
    localparam logic [12:0] VMAX_W  = 13'(VMAX);
    localparam logic [11:0] MIN_BNC = 12'(MIN_BOUNCE);

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [11:0] vel_q, vel_d;
    logic        left_out_q, left_out_d;
    logic        click_pend_q, click_pend_d;
    logic        vsync_q, left_q;

    logic        tick, click, hit, bounce_ok;
    logic [12:0] vel_sum;
    logic [11:0] v_fall, v_rise, v_bounce;
    logic [16:0] y_fall;

    assign tick  = vsync_in & ~vsync_q;
    assign click = mouse_left & ~left_q;

    // Fall candidate: saturate velocity first, then test the integer part of the new y against the floor.
    assign vel_sum   = {1'b0, vel_q} + {1'b0, GRAV};
    assign v_fall    = (vel_sum > VMAX_W) ? VMAX_W[11:0] : vel_sum[11:0];
    assign y_fall    = {1'b0, y_q} + {5'd0, v_fall};
    assign hit       = ({1'b0, y_fall[16:4]} + 14'(HEIGHT)) >= 14'(FLOOR);
    assign v_bounce  = v_fall - (v_fall >> 2);
    assign bounce_ok = BOUNCE_EN && (v_fall >= MIN_BNC);
    assign v_rise    = vel_q - GRAV;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        vel_d        = vel_q;
        left_out_d   = left_out_q;
        click_pend_d = click_pend_q;

        if (state_q == ST_FOLLOW && click) begin
            click_pend_d = 1'b1;
        end

        if (tick) begin
            left_out_d = mouse_left;
            case (state_q)
                ST_FOLLOW: begin
                    x_d = (mouse_xpos > X_MAX) ? X_MAX : mouse_xpos;
                    y_d = {((mouse_ypos > Y_MAX) ? Y_MAX : mouse_ypos), 4'b0000};
                    if (click_pend_q || click) begin
                        click_pend_d = 1'b0;
                        vel_d        = 12'd0;
                        state_d      = ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (hit) begin
                        y_d = Y_FLOOR;
                        if (bounce_ok) begin
                            vel_d   = v_bounce;
                            state_d = ST_RISE;
                        end else begin
                            vel_d   = 12'd0;
                            state_d = ST_STOP;
                        end
                    end else begin
                        y_d   = y_fall[15:0];
                        vel_d = v_fall;
                    end
                end
                ST_RISE: begin
                    if (vel_q <= GRAV) begin
                        vel_d   = 12'd0;
                        state_d = ST_FALL;
                    end else if ({4'd0, v_rise} > y_q) begin
                        y_d     = 16'd0;
                        vel_d   = 12'd0;
                        state_d = ST_FALL;
                    end else begin
                        y_d   = y_q - {4'd0, v_rise};
                        vel_d = v_rise;
                    end
                end
                default: begin
                    // A held button keeps the sprite parked until it is released.
                    if (!mouse_left) begin
                        state_d = ST_FOLLOW;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FOLLOW;
            x_q          <= 12'd0;
            y_q          <= 16'd0;
            vel_q        <= 12'd0;
            left_out_q   <= 1'b0;
            click_pend_q <= 1'b0;
            vsync_q      <= 1'b0;
            left_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vel_q        <= vel_d;
            left_out_q   <= left_out_d;
            click_pend_q <= click_pend_d;
            vsync_q      <= vsync_in;
            left_q       <= mouse_left;
        end
    end

    assign xpos_out  = x_q;
    assign ypos_out  = y_q[15:4];
    assign left_out  = left_out_q;
    assign state_out = state_q;

endmodule
